decode_stage: RTL and testbench

// - Decode/issue stage directly upstream of the integer ALU. Accepts one RV64IM instruction per cycle from fetch.
// - Reads the register file, generates immediates and selects operands (rs1/PC, rs2/imm).
// - Normalises func7 so the ALU's {func3,func7} lookup matches, then registers the result toward execute.
// - Holds a per-register busy scoreboard and stalls on RAW/WAW hazards; no forwarding.

---
 rtl/decode_pkg.sv | 15 +
 rtl/decode_imm_gen.sv | 21 ++
 rtl/decode_stage.sv | 172 +++++++++++++++++
 tb/tb_decode_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcodes and immediate-format selector shared by the decode stage
package decode_pkg;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: sign-extended immediate for the selected format; U is left unshifted
module decode_imm_gen
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:0]           instr_i,
    input  imm_type_e             imm_type_i,
    output logic [DATA_WIDTH-1:0] imm_o
);
    logic s;
    assign s = instr_i[31];
    always_comb begin
        imm_o = imm_type_i == IMM_I ? {{(DATA_WIDTH-12){s}}, instr_i[31:20]} :
                imm_type_i == IMM_S ? {{(DATA_WIDTH-12){s}}, instr_i[31:25], instr_i[11:7]} :
                imm_type_i == IMM_B ? {{(DATA_WIDTH-13){s}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                imm_type_i == IMM_U ? {{(DATA_WIDTH-20){s}}, instr_i[31:12]} :
                imm_type_i == IMM_J ? {{(DATA_WIDTH-21){s}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                '0;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV64IM decode/issue with busy scoreboard, hazard stall and registered execute handoff
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 7,
    parameter int FUNC3_WIDTH    = 3,
    parameter int FUNC7_WIDTH    = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [DATA_WIDTH-1:0]     if_pc,
    input  logic [INSTR_WIDTH-1:0]    if_instr,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0]     rf_rdata1,
    input  logic [DATA_WIDTH-1:0]     rf_rdata2,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
    output logic [FUNC3_WIDTH-1:0]    ex_func3,
    output logic [FUNC7_WIDTH-1:0]    ex_func7,
    output logic [DATA_WIDTH-1:0]     ex_data1,
    output logic [DATA_WIDTH-1:0]     ex_data2,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [DATA_WIDTH-1:0]     ex_rs1_data,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_illegal
);
    localparam int NREGS = 1 << REG_ADDR_WIDTH;
    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic [FUNC3_WIDTH-1:0]    func3;
        logic [FUNC7_WIDTH-1:0]    func7;
        logic [DATA_WIDTH-1:0]     data1;
        logic [DATA_WIDTH-1:0]     data2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [DATA_WIDTH-1:0]     pc;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      illegal;
    } ex_t;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [FUNC3_WIDTH-1:0]    f3;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic uses_rs1, uses_rs2, writes_rd, illegal, pc_src, rs2_src, no_f3, hazard, cap;
    logic [FUNC7_WIDTH-1:0] func7;
    imm_type_e imm_type;
    logic [DATA_WIDTH-1:0] imm;
    logic [NREGS-1:0] busy_q, busy_d;
    logic ex_valid_q;
    ex_t ex_q, ex_d;
    assign op  = if_instr[ALU_OP_WIDTH-1:0];
    assign f3  = if_instr[14:12];
    assign rd  = if_instr[11:7];
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        writes_rd = 1'b0;
        illegal = 1'b0;
        pc_src = 1'b0;
        rs2_src = 1'b0;
        no_f3 = 1'b0;
        imm_type = IMM_NONE;
        func7 = '0;
        case (op)
            OP, OP_32: begin
                {uses_rs1, uses_rs2, writes_rd, rs2_src} = 4'b1111;
                func7 = if_instr[31:25];
            end
            OP_IMM: begin
                {uses_rs1, writes_rd} = 2'b11;
                imm_type = IMM_I;
                // RV64 shamt is 6 bits, so instr[25] is shamt[5], not part of func7
                func7 = f3[1:0] == 2'b01 ? {if_instr[31:26], 1'b0} : '0;
            end
            OP_IMM_32: begin
                {uses_rs1, writes_rd} = 2'b11;
                imm_type = IMM_I;
                func7 = f3[1:0] == 2'b01 ? if_instr[31:25] : '0;
            end
            LOAD: begin
                {uses_rs1, writes_rd} = 2'b11;
                imm_type = IMM_I;
            end
            JALR: begin
                {uses_rs1, writes_rd, pc_src} = 3'b111;
                imm_type = IMM_I;
            end
            STORE: begin
                {uses_rs1, uses_rs2} = 2'b11;
                imm_type = IMM_S;
            end
            BRANCH: begin
                {uses_rs1, uses_rs2, rs2_src} = 3'b111;
                imm_type = IMM_B;
            end
            JAL: begin
                {writes_rd, pc_src, no_f3} = 3'b111;
                imm_type = IMM_J;
            end
            LUI: begin
                {writes_rd, no_f3} = 2'b11;
                imm_type = IMM_U;
            end
            AUIPC: begin
                {writes_rd, pc_src, no_f3} = 3'b111;
                imm_type = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
    end
    decode_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr_i    (if_instr[31:0]),
        .imm_type_i (imm_type),
        .imm_o      (imm)
    );
    assign hazard   = (uses_rs1 & busy_q[rs1]) | (uses_rs2 & busy_q[rs2]) | (writes_rd & busy_q[rd]);
    assign if_ready = ~flush & ~hazard & (~ex_valid_q | ex_ready);
    assign cap      = if_valid & if_ready;
    always_comb begin
        ex_d = '{
            alu_op:     op,
            func3:      no_f3 ? '0 : f3,
            func7:      func7,
            data1:      pc_src ? if_pc : rf_rdata1,
            data2:      rs2_src ? rf_rdata2 : imm,
            imm:        imm,
            rs1_data:   rf_rdata1,
            store_data: rf_rdata2,
            pc:         if_pc,
            rd:         writes_rd ? rd : '0,
            illegal:    illegal
        };
    end
    // Ordering makes a same-index capture set win over a writeback clear
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (flush && ex_valid_q && ex_q.rd != '0) busy_d[ex_q.rd] = 1'b0;
        if (cap && writes_rd && rd != '0) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            ex_valid_q <= 1'b0;
            ex_q <= '0;
        end else begin
            busy_q <= busy_d;
            ex_valid_q <= cap | (ex_valid_q & ~ex_ready & ~flush);
            if (cap) ex_q <= ex_d;
        end
    end
    assign ex_valid = ex_valid_q;
    assign {ex_alu_op, ex_func3, ex_func7, ex_data1, ex_data2, ex_imm, ex_rs1_data,
            ex_store_data, ex_pc, ex_rd, ex_illegal} = ex_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a queue scoreboard and reference decoder
module tb_decode_stage;
    import decode_pkg::*;
    logic clk, rst_n, if_valid, if_ready, wb_valid, flush, ex_valid, ex_ready, ex_illegal;
    logic [63:0] if_pc, rf_rdata1, rf_rdata2, ex_data1, ex_data2, ex_imm, ex_rs1_data, ex_store_data, ex_pc;
    logic [31:0] if_instr;
    logic [4:0] rf_raddr1, rf_raddr2, wb_rd, ex_rd;
    logic [6:0] ex_alu_op, ex_func7;
    logic [2:0] ex_func3;
    typedef struct packed {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        logic [63:0] d1, d2, imm, rs1d, sd, pc;
        logic [4:0] rd; logic ill;
    } pkt_t;
    pkt_t exp_q[$];
    pkt_t act_p;
    bit busy_m [32];
    bit mvalid;
    logic [4:0] cur_rd;
    int errors, checks;
    logic [6:0] ops [12];
    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_alu_op(ex_alu_op), .ex_func3(ex_func3), .ex_func7(ex_func7),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_illegal(ex_illegal)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        return v[w-1] ? v - (64'd1 << w) : v;
    endfunction
    // {reads rs1, reads rs2, writes rd}
    function automatic logic [2:0] usage(input logic [6:0] op);
        if (op == OP || op == OP_32) return 3'b111;
        if (op inside {OP_IMM, OP_IMM_32, LOAD, JALR}) return 3'b101;
        if (op inside {STORE, BRANCH}) return 3'b110;
        if (op inside {JAL, LUI, AUIPC}) return 3'b001;
        return 3'b000;
    endfunction
    function automatic pkt_t ref_dec(input logic [31:0] i, input logic [63:0] pc, a, b);
        pkt_t r;
        logic [63:0] im_i, im_s, im_b, im_u, im_j;
        im_i = sx(64'(i[31:20]), 12);
        im_s = sx(64'({i[31:25], i[11:7]}), 12);
        im_b = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
        im_u = sx(64'(i[31:12]), 20);
        im_j = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
        r = '{op: i[6:0], f3: i[14:12], f7: 7'd0, d1: a, d2: 64'd0, imm: 64'd0,
              rs1d: a, sd: b, pc: pc, rd: i[11:7], ill: 1'b0};
        case (i[6:0])
            OP, OP_32: begin r.f7 = i[31:25]; r.d2 = b; end
            OP_IMM: begin r.imm = im_i; r.d2 = im_i; if (i[13:12] == 2'b01) r.f7 = {i[31:26], 1'b0}; end
            OP_IMM_32: begin r.imm = im_i; r.d2 = im_i; if (i[13:12] == 2'b01) r.f7 = i[31:25]; end
            LOAD: begin r.imm = im_i; r.d2 = im_i; end
            JALR: begin r.imm = im_i; r.d2 = im_i; r.d1 = pc; end
            STORE: begin r.imm = im_s; r.d2 = im_s; r.rd = 0; end
            BRANCH: begin r.imm = im_b; r.d2 = b; r.rd = 0; end
            JAL: begin r.imm = im_j; r.d2 = im_j; r.d1 = pc; r.f3 = 0; end
            LUI: begin r.imm = im_u; r.d2 = im_u; r.f3 = 0; end
            AUIPC: begin r.imm = im_u; r.d2 = im_u; r.d1 = pc; r.f3 = 0; end
            default: begin r.ill = 1'b1; r.rd = 0; end
        endcase
        return r;
    endfunction
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        chk("ex_valid", 64'(ex_valid), 64'(exp_q.size() != 0));
        if (ex_valid && exp_q.size() != 0) begin
            act_p = {ex_alu_op, ex_func3, ex_func7, ex_data1, ex_data2, ex_imm, ex_rs1_data,
                     ex_store_data, ex_pc, ex_rd, ex_illegal};
            checks++;
            if (act_p !== exp_q[0]) begin
                errors++;
                $display("FAIL ex_pkt: got %h expected %h", act_p, exp_q[0]);
            end
            if (ex_ready || flush) void'(exp_q.pop_front());
        end
    end
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc, r1, r2,
                        input logic wv, input logic [4:0] wr, input logic fl, input logic rdy);
        logic [2:0] u;
        logic haz, er, cap;
        pkt_t p;
        @(posedge clk);
        #1;
        if_valid = v; if_instr = ins; if_pc = pc; rf_rdata1 = r1; rf_rdata2 = r2;
        wb_valid = wv; wb_rd = wr; flush = fl; ex_ready = rdy;
        @(negedge clk);
        #1;
        u = usage(ins[6:0]);
        haz = (u[2] && busy_m[ins[19:15]]) || (u[1] && busy_m[ins[24:20]]) || (u[0] && busy_m[ins[11:7]]);
        er = !fl && !haz && (!mvalid || rdy);
        chk("if_ready", 64'(if_ready), 64'(er));
        chk("rf_raddr", 64'({rf_raddr1, rf_raddr2}), 64'({ins[19:15], ins[24:20]}));
        cap = v && er;
        if (wv) busy_m[wr] = 0;
        if (fl && mvalid) busy_m[cur_rd] = 0;
        if (cap) begin
            p = ref_dec(ins, pc, r1, r2);
            exp_q.push_back(p);
            busy_m[p.rd] = 1;
            cur_rd = p.rd;
            mvalid = 1;
        end else if (fl || rdy) mvalid = 0;
        busy_m[0] = 0;
    endtask
    initial begin
        clk = 0; rst_n = 0; errors = 0; checks = 0; mvalid = 0; cur_rd = 0;
        if_valid = 0; if_instr = 0; if_pc = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; ex_ready = 0;
        ops = '{OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, 7'h7F};
        #12;
        chk("reset_outs", 64'(|{ex_valid, ex_alu_op, ex_func3, ex_func7, ex_data1, ex_data2, ex_imm,
            ex_rs1_data, ex_store_data, ex_pc, ex_rd, ex_illegal}), 64'd0);
        @(negedge clk) rst_n = 1;
        step(1, 32'hFFF10093, 64'h1000, 64'd5, 64'd7, 0, 0, 0, 0);
        step(0, 32'h0, 64'h0, 64'd0, 64'd0, 0, 0, 0, 0);
        chk("t1_op", 64'(ex_alu_op), 64'h13);
        chk("t1_f3", 64'(ex_func3), 64'd0);
        chk("t1_f7", 64'(ex_func7), 64'd0);
        chk("t1_d1", ex_data1, 64'd5);
        chk("t1_d2", ex_data2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_rd", 64'(ex_rd), 64'd1);
        step(1, 32'h00108213, 64'h1004, 64'd9, 64'd0, 0, 0, 0, 1);
        chk("t4_stall", 64'(if_ready), 64'd0);
        step(1, 32'h00108213, 64'h1004, 64'd9, 64'd0, 1, 1, 0, 1);
        chk("t4_stall_wb_edge", 64'(if_ready), 64'd0);
        step(1, 32'h00108213, 64'h1004, 64'd42, 64'd0, 0, 0, 0, 1);
        chk("t4_capture", 64'(if_ready), 64'd1);
        step(1, 32'h43F35293, 64'h1008, 64'd3, 64'd0, 0, 0, 0, 1);
        chk("t4_d1", ex_data1, 64'd42);
        step(1, 32'h800001B7, 64'h100C, 64'd0, 64'd0, 0, 0, 0, 1);
        chk("t2_f7", 64'(ex_func7), 64'h20);
        chk("t2_f3", 64'(ex_func3), 64'd5);
        chk("t2_shamt", 64'(ex_data2[5:0]), 64'd63);
        step(0, 32'h0, 64'h0, 64'd0, 64'd0, 0, 0, 0, 0);
        chk("t3_d2", ex_data2, 64'hFFFF_FFFF_FFF8_0000);
        chk("t3_rd", 64'(ex_rd), 64'd3);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h009403B3, 64'h1010, 64'd11, 64'd12, 0, 0, 0, 0);
            chk("t5_hold_ready", 64'(if_ready), 64'd0);
        end
        step(1, 32'h009403B3, 64'h1010, 64'd11, 64'd12, 0, 0, 0, 1);
        chk("t5_no_bubble", 64'(if_ready), 64'd1);
        step(0, 32'h0, 64'h0, 64'd0, 64'd0, 0, 0, 0, 0);
        step(0, 32'h0, 64'h0, 64'd0, 64'd0, 0, 0, 1, 0);
        step(1, 32'h009403B3, 64'h1014, 64'd13, 64'd14, 0, 0, 0, 0);
        chk("t6_flush_valid", 64'(ex_valid), 64'd0);
        chk("t6_busy7_clear", 64'(if_ready), 64'd1);
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r, ins;
            r = $urandom();
            ins = r;
            ins[6:0] = ops[$urandom_range(11)];
            ins[11:7] = {2'b00, r[9:7]};
            ins[19:15] = {2'b00, r[17:15]};
            ins[24:20] = {2'b00, r[22:20]};
            step($urandom_range(9) < 7, ins, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 {$urandom(), $urandom()}, $urandom_range(9) < 3, 5'($urandom_range(7)),
                 $urandom_range(19) == 0, $urandom_range(9) < 6);
        end
        step(1, 32'hFFF10093, 64'h2000, 64'd1, 64'd2, 0, 0, 0, 0);
        step(1, 32'hFFF10093, 64'h2000, 64'd1, 64'd2, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 0;
        if_valid = 0; wb_valid = 0; flush = 0; ex_ready = 0;
        exp_q.delete();
        mvalid = 0;
        foreach (busy_m[k]) busy_m[k] = 0;
        #1;
        chk("rst_async_outs", 64'(|{ex_valid, ex_alu_op, ex_func3, ex_func7, ex_data1, ex_data2, ex_imm,
            ex_rs1_data, ex_store_data, ex_pc, ex_rd, ex_illegal}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1;
        step(1, 32'hFFF10093, 64'h3000, 64'd8, 64'd9, 0, 0, 0, 0);
        chk("rst_busy_clear", 64'(if_ready), 64'd1);
        step(0, 32'h0, 64'h0, 64'd0, 64'd0, 0, 0, 0, 1);
        step(0, 32'h0, 64'h0, 64'd0, 64'd0, 0, 0, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
